// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the architectural fetch PC at the head of the pipeline. It issues one
// instruction-memory request at a time, buffers the returned instruction and
// hands it to decode. Trap and branch redirects retarget the PC and squash any
// stale request, response or buffered instruction.
//
// Ports:
//   clock, reset_n                 pipeline clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel (addr is the current PC)
//   imem_rsp_valid/data            fetch response channel, one response per request
//   fetch_valid/ready/instr/pc     instruction hand-off to decode
//   redirect_valid/target          branch/jump redirect from execute
//   trap_valid/vector              exception/interrupt redirect (wins over redirect)
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDRESS = '0,
    parameter int                    INSTR_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic [ADDR_WIDTH-1:0]  fetch_pc,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    input  logic                   trap_valid,
    input  logic [ADDR_WIDTH-1:0]  trap_vector
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic                   r_drop;
    logic                   w_drop_next;
    logic                   w_capture;
    logic [INSTR_WIDTH-1:0] r_fetch_instr;
    logic [ADDR_WIDTH-1:0]  r_fetch_pc;

    logic                   w_redirect;
    logic [ADDR_WIDTH-1:0]  w_new_pc;

    // Trap beats branch redirect; targets are always word aligned.
    assign w_redirect = trap_valid || redirect_valid;
    assign w_new_pc   = (trap_valid ? trap_vector : redirect_target) & ~ADDR_WIDTH'(3);

    assign imem_req_addr = r_pc;
    assign fetch_instr   = r_fetch_instr;
    assign fetch_pc      = r_fetch_pc;
    // A same-cycle redirect hides the buffered instruction from decode.
    assign fetch_valid   = (r_state == S_HOLD) && !w_redirect;

    // State, PC and squash-flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_BOOT;
            r_pc          <= BOOT_ADDRESS;
            r_drop        <= 1'b0;
            r_fetch_instr <= '0;
            r_fetch_pc    <= BOOT_ADDRESS;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_drop  <= w_drop_next;
            if (w_capture) begin
                r_fetch_instr <= imem_rsp_data;
                r_fetch_pc    <= r_pc;
            end
        end
    end

    // Next-state logic. A redirect takes priority over everything else: it
    // always loads the new PC, and any response still owed for the old PC is
    // marked for dropping so it never reaches decode.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_drop_next    = r_drop;
        w_capture      = 1'b0;
        imem_req_valid = 1'b0;

        case (r_state)
            S_BOOT: begin
                w_state_next = S_REQ;
                if (w_redirect) begin
                    w_pc_next = w_new_pc;
                end
            end

            S_REQ: begin
                imem_req_valid = 1'b1;
                // An unaccepted request may be retargeted in place; an accepted
                // one belongs to the old PC and its response must be dropped.
                if (w_redirect) begin
                    w_pc_next = w_new_pc;
                end
                if (imem_req_ready) begin
                    w_state_next = S_WAIT;
                    w_drop_next  = w_redirect;
                end
            end

            S_WAIT: begin
                if (w_redirect) begin
                    w_pc_next = w_new_pc;
                    if (imem_rsp_valid) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_drop_next  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (w_redirect) begin
                    w_pc_next    = w_new_pc;
                    w_state_next = S_REQ;
                end else if (fetch_ready) begin
                    w_pc_next    = r_pc + ADDR_WIDTH'(4);
                    w_state_next = S_REQ;
                end
            end

            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    // The memory must only answer while a request is outstanding.
    a_rsp_only_in_wait: assert property (
        @(posedge clock) disable iff (!reset_n)
        imem_rsp_valid |-> (r_state == S_WAIT)
    );

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural fetch PC and sequences instruction fetch from the instruction memory port using a valid/ready request channel and a valid response channel.
- Delivers each fetched instruction and its PC to decode over a valid/ready handshake.
- Applies trap and branch redirects from later stages, and squashes any in-flight or buffered stale instruction.
- Sits at the head of the 7-stage pipeline, between the imem port and the fetch/decode register.

Parameters:
ADDR_WIDTH, 32, width of PC and all address ports
BOOT_ADDRESS, 32'h0000_0000, PC value loaded on reset
INSTR_WIDTH, 32, instruction word width

Ports:
clock  in  1  pipeline clock, all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  ADDR_WIDTH  fetch address (equals current PC)
imem_rsp_valid  in  1  response valid; exactly one response per accepted request, ≥1 cycle after acceptance
imem_rsp_data  in  INSTR_WIDTH  fetched instruction
fetch_valid  out  1  instruction available to decode
fetch_ready  in  1  decode accepts instruction
fetch_instr  out  INSTR_WIDTH  buffered instruction
fetch_pc  out  ADDR_WIDTH  PC of fetch_instr
redirect_valid  in  1  branch/jump resolution redirect
redirect_target  in  ADDR_WIDTH  redirect destination
trap_valid  in  1  exception/interrupt redirect
trap_vector  in  ADDR_WIDTH  trap handler address

Behaviour:
- Reset (reset_n=0, async): state=BOOT, pc=BOOT_ADDRESS, drop=0, imem_req_valid=0, fetch_valid=0, fetch_instr=0, fetch_pc=BOOT_ADDRESS. Reset asserted mid-operation discards every pending request, response and buffered instruction. Responses to requests accepted before reset are not expected.
- States:
  - BOOT: always go to REQ next cycle.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go to WAIT.
  - WAIT: on imem_rsp_valid, if drop=1 clear drop and go to REQ; otherwise capture data into fetch_instr, set fetch_pc=pc, go to HOLD.
  - HOLD: fetch_valid asserted. On fetch_valid&&fetch_ready, pc=pc+4 and go to REQ.
- fetch_valid = (state==HOLD) && !trap_valid && !redirect_valid. This is the only combinational input-to-output path.
- Redirect: new_pc = trap_valid ? trap_vector : redirect_target. Trap wins if both are asserted. new_pc[1:0] is forced to 2'b00.
  - REQ, ready=0: pc=new_pc; request stays in REQ with the new address. Our imem allows retargeting an unaccepted request.
  - REQ, ready=1: the old address is accepted; pc=new_pc, drop=1, go to WAIT.
  - WAIT: pc=new_pc, drop=1. If imem_rsp_valid arrives in the same cycle, that response is discarded, drop stays 0, and the state goes to REQ.
  - HOLD: buffered instruction is discarded with no decode handshake, even if fetch_ready=1; pc=new_pc, go to REQ.
  - BOOT: pc=new_pc, go to REQ.
- Redirect takes priority over fetch handshake and over response capture in every state.
- At most one imem request is outstanding. Fetch throughput is at most one instruction per 3 cycles; no prefetch.
- Arithmetic: pc+4 wraps modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC advances to 0x0000_0000.
- imem_rsp_valid outside WAIT is illegal. An assertion must flag it; the design ignores it.

Test Plan:
- Reset release with imem always ready, 1-cycle response latency, decode always ready → requests issued to 0x0, 0x4, 0x8; fetch_pc matches each address, with fetch_valid pulsing every 3 cycles.
- Decode holds fetch_ready=0 for 5 cycles in HOLD → fetch_instr/fetch_pc stable, no new imem request, pc advances only after the handshake.
- redirect_valid, target 0x100, in the same cycle as imem_req_ready for 0x8 → the 0x8 response is dropped (fetch_valid stays 0), the next request is 0x100, and fetch_pc=0x100 is delivered.
- trap_valid (vector 0x200) and redirect_valid (0x300) together in HOLD with fetch_ready=1 → no handshake, buffered instruction discarded, next request 0x200.
- PC at 0xFFFF_FFFC completes a handshake → next request address 0x0000_0000. Separately, redirect target 0x103 → request address 0x100.
- reset_n asserted while in WAIT, then released → outputs return to reset values immediately (asynchronously), and fetching restarts at BOOT_ADDRESS.
